// File: rtl/cmprs_status_mchn.sv
// Per-channel compressor status: registered activity levels, flush tracking between
// stuffer stop and EOF write, sticky done/timeout flags, flush watchdog and masked irq.
module cmprs_status_mchn #(
  parameter int NUM_CHN    = 4,
  parameter int FLUSH_TOUT = 1000,
  parameter int TOUT_BITS  = 16
) (
  input  logic                   mclk,
  input  logic                   mrst,
  input  logic [NUM_CHN-1:0]     eof_written,
  input  logic [NUM_CHN-1:0]     stuffer_running,
  input  logic [NUM_CHN-1:0]     reading_frame,
  input  logic                   irq_mask_we,
  input  logic [NUM_CHN-1:0]     irq_mask_data,
  input  logic [NUM_CHN-1:0]     done_clr,
  input  logic [NUM_CHN-1:0]     tout_clr,
  output logic [5*NUM_CHN-1:0]   status,
  output logic                   irq
);

  localparam logic [TOUT_BITS-1:0] TOUT_MAX = TOUT_BITS'(FLUSH_TOUT);
  localparam logic [TOUT_BITS-1:0] TOUT_PRE = TOUT_BITS'(FLUSH_TOUT - 1);

  logic [NUM_CHN-1:0] irq_mask;
  logic [NUM_CHN-1:0] done_vec;

  generate
    for (genvar gi = 0; gi < NUM_CHN; gi++) begin : g_chn
      logic                 stuffer_r;
      logic                 reading_r;
      logic                 flushing;
      logic                 done;
      logic                 tout;
      logic [TOUT_BITS-1:0] cnt;
      logic                 fall;

      assign fall = stuffer_r & ~stuffer_running[gi];

      always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
          stuffer_r <= 1'b0;
          reading_r <= 1'b0;
          flushing  <= 1'b0;
          done      <= 1'b0;
          tout      <= 1'b0;
          cnt       <= '0;
        end else begin
          stuffer_r <= stuffer_running[gi];
          reading_r <= reading_frame[gi];

          // A stuffer stop always (re)starts a flush, even on the EOF cycle.
          if (fall)
            flushing <= 1'b1;
          else if (eof_written[gi])
            flushing <= 1'b0;

          if (flushing && eof_written[gi] && !fall)
            done <= 1'b1;
          else if (done_clr[gi])
            done <= 1'b0;

          if (fall)
            cnt <= '0;
          else if (flushing && cnt < TOUT_MAX)
            cnt <= cnt + TOUT_BITS'(1);

          // Flag lands together with the counter reaching its saturation value.
          if (flushing && !fall && cnt == TOUT_PRE)
            tout <= 1'b1;
          else if (tout_clr[gi])
            tout <= 1'b0;
        end
      end

      assign status[5*gi +: 5] = {tout, done, flushing, stuffer_r, reading_r};
      assign done_vec[gi]      = done;
    end
  endgenerate

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (irq_mask_we)
        irq_mask <= irq_mask_data;
      irq <= |(done_vec & irq_mask);
    end
  end

endmodule

// File: doc/cmprs_status_mchn.md
Name: cmprs_status_mchn

Overview:
Multi-channel compressor status generator for the JPEG compressor channels. Per channel it tracks:
- frame read activity;
- stuffer activity;
- the FIFO-flush interval between stuffer stop and EOF write.

It adds sticky "frame done" and "flush timeout" flags, a maskable interrupt and a per-channel flush watchdog. It sits between the per-channel compressor cores and the status/interrupt register block on mclk.

Parameters:
NUM_CHN, 4, number of compressor channels (1..16)
FLUSH_TOUT, 1000, mclk cycles of flushing after which timeout is flagged (>=2)
TOUT_BITS, 16, watchdog counter width; must satisfy 2^TOUT_BITS > FLUSH_TOUT

Ports:
mclk  input  1  system clock, all logic on rising edge
mrst  input  1  reset, asynchronous, active-high
eof_written  input  NUM_CHN  per-channel 1-cycle pulse: EOF marker written to memory
stuffer_running  input  NUM_CHN  per-channel level: bit stuffer active
reading_frame  input  NUM_CHN  per-channel level: frame being read from buffer
irq_mask_we  input  1  write strobe for interrupt mask
irq_mask_data  input  NUM_CHN  new mask value (1 = enabled)
done_clr  input  NUM_CHN  per-channel pulse: clear done sticky
tout_clr  input  NUM_CHN  per-channel pulse: clear timeout sticky
status  output  5*NUM_CHN  channel n at [5n+4:5n] = {tout_s, done_s, flushing, stuffer_running_r, reading_frame_r}
irq  output  1  registered OR of (done_s & irq_mask) over channels

Behaviour:
- Channel logic is fully independent per channel. Channel n uses bit n of every vector input.
- Reset (mrst high, async):
  - all registers go to 0: stuffer_running_r, reading_frame_r, flushing, done_s, tout_s, watchdog counter, irq_mask, irq;
  - status = 0, irq = 0 while mrst is asserted and on the first clock after release.
  - Reset mid-flush discards the flush with no done/tout set.
- stuffer_running_r and reading_frame_r are inputs registered by 1 cycle (status latency 1).
- fall = stuffer_running_r & ~stuffer_running (same-cycle comparison of registered and raw input).
- flushing (next value):
  - if fall: 1;
  - else if eof_written: 0;
  - else: hold.
  - fall and eof_written in the same cycle: fall wins, flushing = 1, done not set.
- done_s:
  - set on the cycle flushing transitions 1->0 (flushing=1 & eof_written & ~fall);
  - eof_written while flushing=0 has no effect;
  - cleared by done_clr;
  - set and clear in the same cycle: set wins.
- Watchdog counter (TOUT_BITS):
  - loaded with 0 on fall;
  - increments each cycle while flushing=1 and count < FLUSH_TOUT;
  - saturates at FLUSH_TOUT;
  - held while flushing=0.
- tout_s:
  - set in the cycle the counter reaches FLUSH_TOUT, i.e. exactly FLUSH_TOUT cycles after flushing rose;
  - cleared by tout_clr;
  - set wins over clear.
- A timeout does not clear flushing. A later eof_written still ends the flush and sets done_s.
- A new fall while flushing=1 restarts the counter from 0 and keeps flushing=1. tout_s is not cleared.
- irq_mask: loaded from irq_mask_data on irq_mask_we, 1-cycle latency.
- irq: registered, irq = |(done_s & irq_mask) evaluated on current register values (1 cycle behind done_s/mask). Timeout does not drive irq.

Test Plan:
- Reset: assert mrst asynchronously mid-cycle with stuffer_running=1 on chn0 -> status=0 and irq=0 immediately; after release, status[1] rises 1 cycle after the first clock.
- Normal frame, chn1, mask=4'b0010: stuffer_running 1->0 at cycle T, eof_written at T+10 -> flushing (status[7]) = 1 on cycles T+1..T+10, done_s (status[8]) = 1 at T+11, irq = 1 at T+12; done_clr[1] -> irq = 0 two cycles later.
- Simultaneous: stuffer fall and eof_written same cycle on chn2 -> flushing = 1, done_s stays 0; a later eof_written ends the flush and sets done_s.
- Timeout, FLUSH_TOUT=1000, chn3: stuffer fall, no EOF -> tout_s (status[19]) = 1 exactly 1000 cycles after flushing rises, irq stays 0; eof_written at 1500 -> flushing = 0, done_s = 1; tout_clr[3] -> tout_s = 0.
- Set/clear collision: done_clr[0] in the same cycle as the flush-ending eof_written -> done_s = 1.
- Channel isolation / mask: all 4 channels flush concurrently with staggered EOFs, mask = 4'b0101 -> irq asserts only after chn0 or chn2 done; each channel's status changes only in its own 5-bit field.
